// File: rtl/spi_reg_bank.sv
// SPI-slave configuration register bank: framed write / read-back, reg 0 is a read-only ID word.
// Optional frame-stall timeout is compiled in with SPI_REG_BANK_TIMEOUT_EN.

module spi_slave #(
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int FSB  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_sclk,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [7:0] i_tx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_ss_rise
);
    logic [2:0] r_sclk_s, r_ss_s;
    logic [1:0] r_mosi_s;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_hold;
    logic [7:0] r_hold_data;
    logic       w_rise, w_fall, w_sample, w_done;
    logic [7:0] w_byte;
    logic [2:0] w_txidx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_s <= {3{CPOL != 0}};
            r_ss_s   <= 3'b111;
            r_mosi_s <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], i_sclk};
            r_ss_s   <= {r_ss_s[1:0], i_ss_n};
            r_mosi_s <= {r_mosi_s[0], i_mosi};
        end
    end

    assign w_rise   = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_fall   = ~r_sclk_s[1] & r_sclk_s[2];
    // Sampling edge is the rising edge exactly when CPOL and CPHA agree
    assign w_sample = ~r_ss_s[1] & (((CPOL != 0) ^ (CPHA != 0)) ? w_fall : w_rise);
    assign w_done   = w_sample && (r_bitcnt == 3'd7);
    assign w_byte   = (FSB != 0) ? {r_shift, r_mosi_s[1]} : {r_mosi_s[1], r_shift};

    assign o_rx_valid = r_hold | w_done;
    assign o_rx_data  = r_hold ? r_hold_data : w_byte;
    assign o_ss_rise  = r_ss_s[1] & ~r_ss_s[2];
    assign w_txidx    = (FSB != 0) ? (3'd7 - r_bitcnt) : r_bitcnt;
    assign o_miso     = i_tx_data[w_txidx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_hold      <= 1'b0;
            r_hold_data <= '0;
        end else if (r_ss_s[1]) begin
            r_bitcnt <= '0;
            r_hold   <= 1'b0;
        end else begin
            if (w_sample) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= (FSB != 0) ? {r_shift[5:0], r_mosi_s[1]} : {r_mosi_s[1], r_shift[6:1]};
            end
            // Keep a finished byte until the consumer is ready again
            if (o_rx_valid && !i_rx_ready) begin
                r_hold      <= 1'b1;
                r_hold_data <= o_rx_data;
            end else if (i_rx_ready) begin
                r_hold <= 1'b0;
            end
        end
    end
endmodule

module spi_reg_bank #(
    parameter int          CPOL        = 0,
    parameter int          CPHA        = 0,
    parameter int          FSB         = 1,
    parameter int          ADDR_WIDTH  = 5,
    parameter int          DATA_BYTES  = 4,
    parameter logic [63:0] ID_VALUE    = 64'h4652_0001,
    parameter int          TIMEOUT_CYC = 50000,
    localparam int         NUM_REGS    = 2 ** ADDR_WIDTH,
    localparam int         DW          = 8 * DATA_BYTES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   spi_s_sclk,
    input  logic                   spi_s_ss_n,
    input  logic                   spi_s_mosi,
    output logic                   spi_s_miso,
    output logic                   param_wen,
    output logic [ADDR_WIDTH-1:0]  param_waddr,
    output logic [NUM_REGS*DW-1:0] regs_flat,
    output logic                   frame_err
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_COMMIT} state_t;

    localparam logic [7:0] CMD_WR   = 8'h5A;
    localparam logic [7:0] CMD_RD   = 8'hA5;
    localparam logic [7:0] CMD_CLR  = 8'hC3;
    localparam logic [7:0] HI_MASK  = ~8'((1 << ADDR_WIDTH) - 1);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BYTES - 1);

    state_t                r_state, w_next;
    logic [7:0]            w_rx_data, r_tx_data;
    logic                  w_rx_valid, w_rx_ready, w_accept, w_ss_rise;
    logic                  w_active, w_abort, w_timeout, w_last, w_commit_ok, w_rx_hi_bad;
    logic [ADDR_WIDTH-1:0] w_rx_addr, r_addr;
    logic                  r_is_wr, r_addr_bad;
    logic [2:0]            r_idx;
    logic [DW-1:0]         r_shadow, r_rd_shift, w_rd_word;
    logic [DW-1:0]         r_regs [1:NUM_REGS-1];

    spi_slave #(.CPOL(CPOL), .CPHA(CPHA), .FSB(FSB)) u_spi (
        .clk        (clk),
        .rstn       (rstn),
        .i_sclk     (spi_s_sclk),
        .i_ss_n     (spi_s_ss_n),
        .i_mosi     (spi_s_mosi),
        .o_miso     (spi_s_miso),
        .i_tx_data  (r_tx_data),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .i_rx_ready (w_rx_ready),
        .o_ss_rise  (w_ss_rise)
    );

    assign w_rx_ready  = (r_state != S_COMMIT);
    assign w_accept    = w_rx_valid & w_rx_ready;
    assign w_active    = (r_state == S_ADDR) || (r_state == S_WDATA) || (r_state == S_RDATA);
    assign w_abort     = w_active & (w_ss_rise | w_timeout);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_commit_ok = !r_addr_bad && (r_addr != '0);
    assign w_rx_addr   = w_rx_data[ADDR_WIDTH-1:0];
    assign w_rx_hi_bad = |(w_rx_data & HI_MASK);
    assign w_rd_word   = w_rx_hi_bad ? '0 : regs_flat[w_rx_addr*DW +: DW];

`ifdef SPI_REG_BANK_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                      r_to_cnt <= '0;
        else if (!w_active || w_accept) r_to_cnt <= '0;
        else                            r_to_cnt <= r_to_cnt + 32'd1;
    end
    assign w_timeout = (r_to_cnt >= 32'(TIMEOUT_CYC));
`else
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && (w_rx_data == CMD_WR || w_rx_data == CMD_RD)) w_next = S_ADDR;
            S_ADDR:   if (w_accept) w_next = r_is_wr ? S_WDATA : S_RDATA;
            S_WDATA:  if (w_accept && w_last) w_next = S_COMMIT;
            S_RDATA:  if (w_accept && w_last) w_next = S_IDLE;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_addr_bad  <= 1'b0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_rd_shift  <= '0;
            r_tx_data   <= '0;
            param_wen   <= 1'b0;
            param_waddr <= '0;
            frame_err   <= 1'b0;
        end else begin
            param_wen <= 1'b0;
            if (w_abort) begin
                r_tx_data <= '0;
                frame_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_is_wr <= (w_rx_data == CMD_WR);
                        if (w_rx_data == CMD_CLR) frame_err <= 1'b0;
                    end
                    S_ADDR: if (w_accept) begin
                        r_addr     <= w_rx_addr;
                        r_addr_bad <= w_rx_hi_bad;
                        r_idx      <= '0;
                        if (!r_is_wr) begin
                            r_tx_data  <= w_rd_word[7:0];
                            r_rd_shift <= w_rd_word >> 8;
                        end
                    end
                    S_WDATA: if (w_accept) begin
                        r_shadow[8*r_idx +: 8] <= w_rx_data;
                        r_idx                  <= r_idx + 3'd1;
                    end
                    S_RDATA: if (w_accept) begin
                        r_idx      <= r_idx + 3'd1;
                        r_tx_data  <= w_last ? 8'h00 : r_rd_shift[7:0];
                        r_rd_shift <= r_rd_shift >> 8;
                    end
                    S_COMMIT: begin
                        param_wen <= w_commit_ok;
                        if (w_commit_ok) param_waddr <= r_addr;
                        else             frame_err   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign regs_flat[DW-1:0] = DW'(ID_VALUE);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                r_regs[r] <= '0;
            else if (r_state == S_COMMIT && w_commit_ok && r_addr == ADDR_WIDTH'(r))
                r_regs[r] <= r_shadow;
        end
        assign regs_flat[r*DW +: DW] = r_regs[r];
    end
endmodule
